// File: rtl/mpm_port_requester.sv
// Initiator for the multi-ported XOR memory: per-port request holding, RAW/WAW hazard
// blocking and read response return. Define MPM_REQ_FWD_EN to forward last-cycle writes to reads.
module mpm_port_requester #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PORTS = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_valid,
  output logic [PORTS-1:0]       req_ready,
  input  logic [PORTS-1:0]       req_we,
  input  logic [PORTS*AW-1:0]    req_addr,
  input  logic [PORTS*WIDTH-1:0] req_wdata,
  output logic [PORTS-1:0]       rsp_valid,
  output logic [PORTS*WIDTH-1:0] rsp_rdata,
  output logic [PORTS*AW-1:0]    mem_addr,
  output logic [PORTS*WIDTH-1:0] mem_d,
  output logic [PORTS-1:0]       mem_en,
  input  logic [PORTS*WIDTH-1:0] mem_q,
  output logic [15:0]            stall_cnt
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready;
  // req_ready does not depend on req_valid. rsp_valid is a pulse with no backpressure.
  logic [PORTS-1:0] hold_v;
  logic [PORTS-1:0] hold_we;
  logic [AW-1:0]    hold_addr  [PORTS];
  logic [WIDTH-1:0] hold_wdata [PORTS];

  logic [PORTS-1:0] prev_wr_v;
  logic [AW-1:0]    prev_wr_addr [PORTS];
  logic [PORTS-1:0] rd_pend;
  logic [WIDTH-1:0] last_rdata [PORTS];
  logic [WIDTH-1:0] rsp_cur    [PORTS];

  logic [PORTS-1:0] issue;
  logic [PORTS-1:0] blocked;

`ifdef MPM_REQ_FWD_EN
  logic [WIDTH-1:0] prev_wr_data [PORTS];
  logic [PORTS-1:0] fwd_hit;
  logic [WIDTH-1:0] fwd_data_c   [PORTS];
  logic [PORTS-1:0] fwd_v;
  logic [WIDTH-1:0] fwd_data     [PORTS];
`endif

  // Ports are resolved in index order so a write sees which lower ports already issued.
  always_comb begin : arb_blk
    logic [PORTS-1:0] iss;
    logic raw_hit;
    logic waw_hit;
    iss     = '0;
    blocked = '0;
    raw_hit = 1'b0;
    waw_hit = 1'b0;
`ifdef MPM_REQ_FWD_EN
    fwd_hit = '0;
    for (int p = 0; p < PORTS; p++) fwd_data_c[p] = '0;
`endif
    for (int p = 0; p < PORTS; p++) begin
      raw_hit = 1'b0;
      waw_hit = 1'b0;
      for (int q = 0; q < PORTS; q++) begin
        if (prev_wr_v[q] && prev_wr_addr[q] == hold_addr[p]) begin
`ifdef MPM_REQ_FWD_EN
          fwd_hit[p]    = 1'b1;
          fwd_data_c[p] = prev_wr_data[q];
`else
          raw_hit = 1'b1;
`endif
        end
        if (q < p && iss[q] && hold_we[q] && hold_addr[q] == hold_addr[p]) waw_hit = 1'b1;
      end
      blocked[p] = !rst && hold_v[p] && (hold_we[p] ? waw_hit : raw_hit);
      iss[p]     = !rst && hold_v[p] && !blocked[p];
    end
    issue = iss;
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rsp_cur[p] = mem_q[p*WIDTH +: WIDTH];
`ifdef MPM_REQ_FWD_EN
      if (fwd_v[p]) rsp_cur[p] = fwd_data[p];
`endif
    end
  end

  always_comb begin
    req_ready = '0;
    mem_en    = '0;
    mem_d     = '0;
    mem_addr  = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int p = 0; p < PORTS; p++) begin
      req_ready[p]                = !rst && (!hold_v[p] || issue[p]);
      mem_en[p]                   = issue[p] && hold_we[p];
      mem_addr[p*AW +: AW]        = hold_addr[p];
      mem_d[p*WIDTH +: WIDTH]     = mem_en[p] ? hold_wdata[p] : '0;
      rsp_valid[p]                = rd_pend[p] && !rst;
      rsp_rdata[p*WIDTH +: WIDTH] = rsp_valid[p] ? rsp_cur[p] : last_rdata[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v    <= '0;
      prev_wr_v <= '0;
      rd_pend   <= '0;
      stall_cnt <= '0;
      for (int p = 0; p < PORTS; p++) last_rdata[p] <= '0;
`ifdef MPM_REQ_FWD_EN
      fwd_v <= '0;
`endif
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (req_ready[p]) begin
          hold_v[p] <= req_valid[p];
          if (req_valid[p]) begin
            hold_we[p]    <= req_we[p];
            hold_addr[p]  <= req_addr[p*AW +: AW];
            hold_wdata[p] <= req_wdata[p*WIDTH +: WIDTH];
          end
        end
        prev_wr_v[p]    <= issue[p] && hold_we[p];
        prev_wr_addr[p] <= hold_addr[p];
        rd_pend[p]      <= issue[p] && !hold_we[p];
        if (rsp_valid[p]) last_rdata[p] <= rsp_cur[p];
`ifdef MPM_REQ_FWD_EN
        prev_wr_data[p] <= hold_wdata[p];
        fwd_v[p]        <= issue[p] && !hold_we[p] && fwd_hit[p];
        fwd_data[p]     <= fwd_data_c[p];
`endif
      end
      if (|blocked && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mpm_port_requester.sv
// Directed bench for mpm_port_requester with a behavioural two-port memory
// (1-cycle read latency, writes visible two cycles on) and a read-response scoreboard.
module tb_mpm_port_requester;

  localparam int W = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam bit FWD =
`ifdef MPM_REQ_FWD_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*W-1:0]  req_wdata;
  logic [1:0]    rsp_valid;
  logic [2*W-1:0]  rsp_rdata;
  logic [2*AW-1:0] mem_addr;
  logic [2*W-1:0]  mem_d;
  logic [1:0]    mem_en;
  logic [2*W-1:0]  mem_q;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] mem_seed;

  // clock / reset
  always #5 clk = ~clk;

  mpm_port_requester #(.WIDTH(W), .DEPTH(DEPTH), .PORTS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q),
    .stall_cnt(stall_cnt)
  );

  // memory model: writes land one edge late so they reach reads issued >=2 cycles later
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  q_r [2];
  logic [1:0]    pend_en;
  logic [AW-1:0] pend_a [2];
  logic [W-1:0]  pend_d [2];

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) q_r[p] <= mem[mem_addr[p*AW +: AW]];
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(i) ^ mem_seed;
      pend_en <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) if (pend_en[p]) mem[pend_a[p]] <= pend_d[p];
      pend_en <= mem_en;
    end
    for (int p = 0; p < 2; p++) begin
      pend_a[p] <= mem_addr[p*AW +: AW];
      pend_d[p] <= mem_d[p*W +: W];
    end
  end
  assign mem_q = {q_r[1], q_r[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sl(input logic [15:0] v, input int p);
    return v[p*8 +: 8];
  endfunction

  // driver tasks
  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[p] = v;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*W +: W] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
  endtask

  // scoreboard: every read response pops its port's expected queue
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rsp_valid[p] === 1'b1) begin
        if (p == 0) begin
          if (exp_q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
          else check("rsp0_data", sl(rsp_rdata, 0), exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
          else check("rsp1_data", sl(rsp_rdata, 1), exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    mem_seed = 8'($urandom_range(1, 255));
    rst = 1'b1;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    req_valid = 2'b11;

    // reset: two edges with valid high
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check("rst_ready", req_ready, 2'b00);
      check("rst_mem_en", mem_en, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_stall", stall_cnt, 16'd0);
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post_rst_ready", req_ready, 2'b11);

    // RAW: port0 writes 5 at T, port1 read of 5 held at T+1
    next_cycle();
    set_req(0, 1'b1, 1'b1, 8'd5, 8'hA5);
    @(negedge clk);
    check("raw_wr_ready", req_ready[0], 1'b1);
    next_cycle();
    idle();
    set_req(1, 1'b1, 1'b0, 8'd5, 8'h00);
    @(negedge clk);
    check("raw_wr_en", mem_en, 2'b01);
    check("raw_wr_addr", sl(mem_addr, 0), 8'd5);
    check("raw_wr_d", sl(mem_d, 0), 8'hA5);
    exp_q1.push_back(8'hA5);
    next_cycle();
    idle();
    @(negedge clk);
    check("raw_t1_ready", req_ready[1], FWD);
    check("raw_t1_mem_en", mem_en, 2'b00);
    check("raw_t1_rsp", rsp_valid, 2'b00);
    next_cycle();
    @(negedge clk);
    check("raw_t2_rsp", rsp_valid, FWD ? 2'b10 : 2'b00);
    next_cycle();
    @(negedge clk);
    check("raw_t3_rsp", rsp_valid, FWD ? 2'b00 : 2'b10);
    if (!FWD) exp_stall++;
    check("raw_stall", stall_cnt, 16'(exp_stall));

    // WAW: both ports write 9 in the same cycle; lower port first
    next_cycle();
    set_req(0, 1'b1, 1'b1, 8'd9, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'd9, 8'h22);
    next_cycle();
    idle();
    @(negedge clk);
    check("waw_t0_en", mem_en, 2'b01);
    check("waw_t0_d0", sl(mem_d, 0), 8'h11);
    check("waw_t0_ready", req_ready, 2'b01);
    exp_stall++;
    next_cycle();
    set_req(0, 1'b1, 1'b0, 8'd9, 8'h00);
    @(negedge clk);
    check("waw_t1_en", mem_en, 2'b10);
    check("waw_t1_addr1", sl(mem_addr, 1), 8'd9);
    check("waw_t1_d1", sl(mem_d, 1), 8'h22);
    exp_q0.push_back(8'h22);
    next_cycle();
    idle();
    @(negedge clk);
    check("waw_rd_ready", req_ready[0], FWD);
    if (!FWD) exp_stall++;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("waw_stall", stall_cnt, 16'(exp_stall));

    // same-cycle read/write: read sees old data, later read sees new data
    next_cycle();
    set_req(0, 1'b1, 1'b1, 8'd7, 8'h00);
    next_cycle();
    idle();
    @(negedge clk);
    check("rw_init_en", mem_en, 2'b01);
    next_cycle();
    set_req(0, 1'b1, 1'b1, 8'd7, 8'h3C);
    set_req(1, 1'b1, 1'b0, 8'd7, 8'h00);
    next_cycle();
    idle();
    @(negedge clk);
    check("rw_same_en", mem_en, 2'b01);
    check("rw_same_addr1", sl(mem_addr, 1), 8'd7);
    check("rw_same_ready", req_ready, 2'b11);
    exp_q1.push_back(8'h00);
    next_cycle();
    set_req(1, 1'b1, 1'b0, 8'd7, 8'h00);
    next_cycle();
    idle();
    @(negedge clk);
    check("rw_late_ready", req_ready[1], 1'b1);
    exp_q1.push_back(8'h3C);
    next_cycle();
    next_cycle();

    // streaming reads 0..3 on port0
    next_cycle();
    set_req(0, 1'b1, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    check("stream_ready0", req_ready[0], 1'b1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k < 4) set_req(0, 1'b1, 1'b0, 8'(k), 8'h00);
      else idle();
      @(negedge clk);
      check("stream_addr", sl(mem_addr, 0), 8'(k - 1));
      check("stream_en", mem_en[0], 1'b0);
      check("stream_ready", req_ready[0], 1'b1);
      check("stream_rsp_v", rsp_valid[0], (k >= 2));
      exp_q0.push_back(8'(k - 1) ^ mem_seed);
    end
    next_cycle();
    @(negedge clk);
    check("stream_rsp_last", rsp_valid[0], 1'b1);
    next_cycle();
    @(negedge clk);
    check("stream_rsp_end", rsp_valid[0], 1'b0);

    // reset mid-flight: read issued, then reset in the following cycle
    next_cycle();
    set_req(0, 1'b1, 1'b0, 8'd1, 8'h00);
    next_cycle();
    idle();
    set_req(1, 1'b1, 1'b0, 8'd2, 8'h00);
    @(negedge clk);
    check("mid_issue_addr", sl(mem_addr, 0), 8'd1);
    next_cycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    check("mid_rst_rsp", rsp_valid, 2'b00);
    check("mid_rst_en", mem_en, 2'b00);
    check("mid_rst_ready", req_ready, 2'b00);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_ready", req_ready, 2'b11);
    check("mid_post_en", mem_en, 2'b00);
    check("mid_post_rsp", rsp_valid, 2'b00);
    check("mid_post_stall", stall_cnt, 16'd0);
    check("mid_post_rdata", rsp_rdata, 16'h0000);
    next_cycle();
    @(negedge clk);
    check("mid_late_rsp", rsp_valid, 2'b00);

    check("q0_drained", exp_q0.size(), 32'd0);
    check("q1_drained", exp_q1.size(), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
